perceptron_train_ctrl: RTL and testbench

Training sequencer for the perceptron neuron datapath (x1/x2/t sample ROM, w1/w2/bias registers, y accumulator, error compare). It walks the training ROM sample by sample and pulses the datapath load and update enables. It repeats epochs until one full epoch produces no error or the epoch limit is reached, then asserts ready.

---
 rtl/perceptron_train_ctrl.sv | 177 +++++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_train_ctrl.sv
// ----------------------------------------------------------------------------
// perceptron_train_ctrl
//
// Training sequencer for the perceptron neuron datapath. The datapath holds
// the x1/x2/t sample ROM, the w1/w2/bias registers, the y accumulator and the
// error compare. This block walks the ROM one sample at a time and pulses
// the datapath enables. It repeats epochs until a whole epoch is error-free
// or MAX_EPOCHS epochs have run, then raises ready_o.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active low
//   start_i      begin a training run; only looked at in IDLE and DONE
//   err_i        datapath error flag for the current sample; used in CHECK
//   rom_addr_o   training ROM address (the ROM is combinational)
//   clr_w_o      clear w1, w2 and bias
//   ld_x_o       load the x1, x2 and t registers from the ROM word
//   ld_y_o       register y = w1*x1 + w2*x2 + bias
//   upd_w_o      apply the weight/bias update for the current sample
//   busy_o       high in every state except IDLE and DONE
//   ready_o      training finished; high only in DONE
//   converged_o  valid while ready_o is high; 1 = last epoch was error-free
//   epoch_cnt_o  number of epochs completed in the current run
//
// States
//   S_IDLE      | waiting for the first start after reset
//   S_CLEAR     | weights cleared, run bookkeeping reset
//   S_FETCH     | ROM address settling
//   S_LOAD      | x1/x2/t loaded from ROM
//   S_EVAL      | y computed
//   S_CHECK     | err sampled, weights updated on error, address advanced
//   S_EPOCH_END | epoch count bumped; stop or start another epoch
//   S_DONE      | training finished, result held until the next start
// ----------------------------------------------------------------------------
module perceptron_train_ctrl #(
  parameter int N_SAMPLES  = 100,
  parameter int ADDR_W     = 7,
  parameter int MAX_EPOCHS = 1000,
  parameter int EPOCH_W    = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               err_i,
  output logic [ADDR_W-1:0]  rom_addr_o,
  output logic               clr_w_o,
  output logic               ld_x_o,
  output logic               ld_y_o,
  output logic               upd_w_o,
  output logic               busy_o,
  output logic               ready_o,
  output logic               converged_o,
  output logic [EPOCH_W-1:0] epoch_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LOAD,
    S_EVAL,
    S_CHECK,
    S_EPOCH_END,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_LIM = EPOCH_W'(MAX_EPOCHS);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic [EPOCH_W-1:0]   epoch_cnt_q, epoch_cnt_d;
  logic                 converged_q, converged_d;
  logic                 epoch_err_q, epoch_err_d;
  logic                 clr_w_q, ld_x_q, ld_y_q, busy_q, ready_q;
  logic                 check_q;
  logic [EPOCH_W-1:0]   epoch_next;

  assign epoch_next = epoch_cnt_q + EPOCH_W'(1);

  // Next-state and bookkeeping decode.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    epoch_cnt_d = epoch_cnt_q;
    converged_d = converged_q;
    epoch_err_d = epoch_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Run bookkeeping is cleared on entry to CLEAR so that epoch_cnt and
        // converged already read 0 in the same cycle clr_w is pulsed.
        if (start_i) begin
          state_d     = S_CLEAR;
          rom_addr_d  = '0;
          epoch_cnt_d = '0;
          converged_d = 1'b0;
          epoch_err_d = 1'b0;
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_EVAL;
      S_EVAL:  state_d = S_CHECK;
      S_CHECK: begin
        if (err_i) begin
          epoch_err_d = 1'b1;
        end
        if (rom_addr_q == LAST_ADDR) begin
          state_d = S_EPOCH_END;
        end else begin
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          state_d    = S_FETCH;
        end
      end
      S_EPOCH_END: begin
        // epoch_err_q already includes the final CHECK of this epoch.
        epoch_cnt_d = epoch_next;
        if (!epoch_err_q) begin
          state_d     = S_DONE;
          converged_d = 1'b1;
        end else if (epoch_next == EPOCH_LIM) begin
          state_d     = S_DONE;
          converged_d = 1'b0;
        end else begin
          rom_addr_d  = '0;
          epoch_err_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, bookkeeping and registered outputs. Outputs are decoded from the
  // next state so each enable lines up with the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      epoch_cnt_q <= '0;
      converged_q <= 1'b0;
      epoch_err_q <= 1'b0;
      clr_w_q     <= 1'b0;
      ld_x_q      <= 1'b0;
      ld_y_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      check_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      epoch_cnt_q <= epoch_cnt_d;
      converged_q <= converged_d;
      epoch_err_q <= epoch_err_d;
      clr_w_q     <= (state_d == S_CLEAR);
      ld_x_q      <= (state_d == S_LOAD);
      ld_y_q      <= (state_d == S_EVAL);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      ready_q     <= (state_d == S_DONE);
      check_q     <= (state_d == S_CHECK);
    end
  end

  // err is only valid during CHECK, so the update enable is the registered
  // CHECK flag gated by the live error; outside CHECK err has no effect.
  assign upd_w_o     = check_q & err_i;
  assign rom_addr_o  = rom_addr_q;
  assign clr_w_o     = clr_w_q;
  assign ld_x_o      = ld_x_q;
  assign ld_y_o      = ld_y_q;
  assign busy_o      = busy_q;
  assign ready_o     = ready_q;
  assign converged_o = converged_q;
  assign epoch_cnt_o = epoch_cnt_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
module tb_perceptron_train_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int ME = 3;
  localparam int EW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          err_i;
  logic [AW-1:0] rom_addr_o;
  logic          clr_w_o, ld_x_o, ld_y_o, upd_w_o, busy_o, ready_o, converged_o;
  logic [EW-1:0] epoch_cnt_o;

  always #5 clk_i = ~clk_i;

  perceptron_train_ctrl #(
    .N_SAMPLES (N),
    .ADDR_W    (AW),
    .MAX_EPOCHS(ME),
    .EPOCH_W   (EW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .err_i      (err_i),
    .rom_addr_o (rom_addr_o),
    .clr_w_o    (clr_w_o),
    .ld_x_o     (ld_x_o),
    .ld_y_o     (ld_y_o),
    .upd_w_o    (upd_w_o),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .converged_o(converged_o),
    .epoch_cnt_o(epoch_cnt_o)
  );

  // err scenarios: 0 never, 1 only at address 2 of the first epoch, 2 always.
  int err_mode = 0;
  assign err_i = (err_mode == 2) ? 1'b1 :
                 (err_mode == 1) ? ((rom_addr_o == 2'd2) && (epoch_cnt_o == '0)) :
                 1'b0;

  int tests = 0;
  int fails = 0;
  int n;
  int clr_cnt, ldx_cnt, ldy_cnt, upd_cnt;
  int ldx_addr[$];
  bit inj_pending, inj_active, inj_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n       = 0;
    clr_cnt = 0;
    ldx_cnt = 0;
    ldy_cnt = 0;
    upd_cnt = 0;
    ldx_addr.delete();
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    n++;
    if (clr_w_o) clr_cnt++;
    if (ld_x_o) begin
      ldx_cnt++;
      ldx_addr.push_back(int'(rom_addr_o));
    end
    if (ld_y_o)  ldy_cnt++;
    if (upd_w_o) upd_cnt++;
    if (inj_active) begin
      start_i    = 1'b0;
      inj_active = 1'b0;
    end
    if (inj_pending && ld_y_o) begin
      start_i     = 1'b1;
      inj_pending = 1'b0;
      inj_active  = 1'b1;
      inj_done    = 1'b1;
    end
  endtask

  task automatic run_to_ready(input int limit);
    while (!ready_o && n < limit) step();
    chk("ready_reached", 32'(ready_o), 32'd1);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b0;
    start_i     = 1'b1;
    inj_pending = 1'b0;
    inj_active  = 1'b0;
    inj_done    = 1'b0;
    clear_counts();

    // Reset held with start high: everything idle.
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready",     32'(ready_o),     32'd0);
    chk("rst_busy",      32'(busy_o),      32'd0);
    chk("rst_clr_w",     32'(clr_w_o),     32'd0);
    chk("rst_ld_x",      32'(ld_x_o),      32'd0);
    chk("rst_ld_y",      32'(ld_y_o),      32'd0);
    chk("rst_upd_w",     32'(upd_w_o),     32'd0);
    chk("rst_converged", 32'(converged_o), 32'd0);
    chk("rst_epoch",     32'(epoch_cnt_o), 32'd0);
    chk("rst_addr",      32'(rom_addr_o),  32'd0);

    // Release reset with start still high: CLEAR on the next edge, then an
    // error-free single epoch (ready at k+19).
    rst_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("t1_clr_w", 32'(clr_w_o), 32'd1);
    chk("t1_busy",  32'(busy_o),  32'd1);
    run_to_ready(100);
    chk("t1_done_cycle", 32'(n),           32'd19);
    chk("t1_clr_cnt",    32'(clr_cnt),     32'd1);
    chk("t1_ldx_cnt",    32'(ldx_cnt),     32'd4);
    chk("t1_ldy_cnt",    32'(ldy_cnt),     32'd4);
    chk("t1_upd_cnt",    32'(upd_cnt),     32'd0);
    chk("t1_converged",  32'(converged_o), 32'd1);
    chk("t1_epoch",      32'(epoch_cnt_o), 32'd1);
    chk("t1_busy_done",  32'(busy_o),      32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < ldx_addr.size()) chk("t1_ldx_addr", 32'(ldx_addr[i]), 32'(i));
    end

    // Restart from DONE, one error at address 2 of epoch 1, plus a stray
    // start during EVAL that must be ignored. Done at k+36 after 2 epochs.
    err_mode = 1;
    clear_counts();
    inj_pending = 1'b1;
    pulse_start();
    chk("t2_clr_w",      32'(clr_w_o),     32'd1);
    chk("t2_epoch0",     32'(epoch_cnt_o), 32'd0);
    chk("t2_conv0",      32'(converged_o), 32'd0);
    chk("t2_ready0",     32'(ready_o),     32'd0);
    run_to_ready(100);
    chk("t2_inj_done",   32'(inj_done),    32'd1);
    chk("t2_done_cycle", 32'(n),           32'd36);
    chk("t2_clr_cnt",    32'(clr_cnt),     32'd1);
    chk("t2_ldx_cnt",    32'(ldx_cnt),     32'd8);
    chk("t2_upd_cnt",    32'(upd_cnt),     32'd1);
    chk("t2_converged",  32'(converged_o), 32'd1);
    chk("t2_epoch",      32'(epoch_cnt_o), 32'd2);

    // err always high: gives up after MAX_EPOCHS=3, done at k+53.
    err_mode = 2;
    clear_counts();
    pulse_start();
    run_to_ready(100);
    chk("t3_done_cycle", 32'(n),           32'd53);
    chk("t3_upd_cnt",    32'(upd_cnt),     32'd12);
    chk("t3_converged",  32'(converged_o), 32'd0);
    chk("t3_epoch",      32'(epoch_cnt_o), 32'd3);
    chk("t3_addr_max",   32'(rom_addr_o),  32'd3);
    clear_counts();
    repeat (3) step();
    chk("t3_hold_ready", 32'(ready_o),     32'd1);
    chk("t3_hold_epoch", 32'(epoch_cnt_o), 32'd3);
    chk("t3_hold_upd",   32'(upd_cnt),     32'd0);

    // Reset in the middle of an epoch at address 2.
    err_mode = 0;
    clear_counts();
    pulse_start();
    while (!(ld_x_o && rom_addr_o == 2'd2) && n < 50) step();
    chk("t5_reached_addr2", 32'(ld_x_o && rom_addr_o == 2'd2), 32'd1);
    rst_i = 1'b0;
    clear_counts();
    step();
    rst_i = 1'b1;
    chk("t5_busy",  32'(busy_o),     32'd0);
    chk("t5_ready", 32'(ready_o),    32'd0);
    chk("t5_addr",  32'(rom_addr_o), 32'd0);
    chk("t5_epoch", 32'(epoch_cnt_o), 32'd0);
    repeat (10) step();
    chk("t5_pulses", 32'(clr_cnt + ldx_cnt + ldy_cnt + upd_cnt), 32'd0);
    chk("t5_idle_busy", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
